lsu_data_port: RTL and testbench

Load/store initiator that drives the byte-laned 32-bit data memory, which has separate read and write addresses, a 4-bit per-lane write enable and a synchronous read. It accepts one scalar load or store request at a time from the core datapath. For stores it generates the lane mask and lane-aligned write data. For loads it waits out the memory read latency, then extracts and sign- or zero-extends the result. Misaligned and illegal-size requests are rejected without touching memory.

---
 rtl/lsu_data_port.sv | 159 +++++++++++++++
 tb/tb_lsu_data_port.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_port.sv
// Load/store initiator for a byte-laned 32-bit data memory with a synchronous read port.
// Serves one scalar request at a time; misaligned or illegal-size requests never reach memory.
module lsu_data_port #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic [31:0] mem_raddr,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wr,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STORE     = 2'd1,
      LOAD_WAIT = 2'd2,
      RESP      = 2'd3
   } state_t;

   state_t      state_r;
   logic [2:0]  latCnt_r;
   logic [1:0]  opSize_r;
   logic        zeroExt_r;
   logic [1:0]  laneOff_r;

   logic        accept_s;
   logic        reqFault_s;
   logic [3:0]  laneMask_s;
   logic [31:0] alignedAddr_s;
   logic [31:0] laneWdata_s;
   logic [31:0] loadResult_s;

   function automatic logic [31:0] extendLoad(input logic [31:0] raw, input logic [1:0] size,
                                              input logic zext);
      logic [31:0] res;
      case (size)
         2'b00:   res = {{24{~zext & raw[7]}}, raw[7:0]};
         2'b01:   res = {{16{~zext & raw[15]}}, raw[15:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

   assign accept_s      = req_valid & req_ready;
   assign reqFault_s    = (req_size == 2'b11)
                        | ((req_size == 2'b01) & req_addr[0])
                        | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
   assign alignedAddr_s = {req_addr[31:2], 2'b00};
   assign laneWdata_s   = req_wdata << {req_addr[1:0], 3'b000};
   assign loadResult_s  = extendLoad(mem_rdata >> {laneOff_r, 3'b000}, opSize_r, zeroExt_r);

   // Byte-lane write mask for the incoming store
   always_comb begin
      laneMask_s = 4'b0000;
      case (req_size)
         2'b00:   laneMask_s = 4'b0001 << req_addr[1:0];
         2'b01:   laneMask_s = 4'b0011 << req_addr[1:0];
         2'b10:   laneMask_s = 4'b1111;
         default: laneMask_s = 4'b0000;
      endcase
   end

   // Request/response sequencer; every output is a register of this block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_fault <= 1'b0;
         rsp_rdata <= 32'h0000_0000;
         mem_raddr <= 32'h0000_0000;
         mem_waddr <= 32'h0000_0000;
         mem_wdata <= 32'h0000_0000;
         mem_wr    <= 4'b0000;
         latCnt_r  <= 3'd0;
         opSize_r  <= 2'b00;
         zeroExt_r <= 1'b0;
         laneOff_r <= 2'b00;
      end else begin
         case (state_r)
            IDLE: begin
               mem_wr <= 4'b0000;
               if (accept_s) begin
                  req_ready <= 1'b0;
                  if (reqFault_s) begin
                     rsp_valid <= 1'b1;
                     rsp_fault <= 1'b1;
                     rsp_rdata <= 32'h0000_0000;
                     state_r   <= RESP;
                  end else if (req_we) begin
                     mem_waddr <= alignedAddr_s;
                     mem_wdata <= laneWdata_s;
                     mem_wr    <= laneMask_s;
                     state_r   <= STORE;
                  end else begin
                     mem_raddr <= alignedAddr_s;
                     opSize_r  <= req_size;
                     zeroExt_r <= req_unsigned;
                     laneOff_r <= req_addr[1:0];
                     latCnt_r  <= 3'(MEM_LATENCY);
                     state_r   <= LOAD_WAIT;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            STORE: begin
               mem_wr    <= 4'b0000;
               rsp_valid <= 1'b1;
               rsp_fault <= 1'b0;
               rsp_rdata <= 32'h0000_0000;
               state_r   <= RESP;
            end
            LOAD_WAIT: begin
               // Counter runs out on the edge that registers mem_rdata; capture one edge later
               if (latCnt_r == 3'd0) begin
                  rsp_valid <= 1'b1;
                  rsp_fault <= 1'b0;
                  rsp_rdata <= loadResult_s;
                  state_r   <= RESP;
               end else begin
                  latCnt_r <= latCnt_r - 3'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_fault <= 1'b0;
                  req_ready <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  rsp_valid <= 1'b1;
               end
            end
            default: begin
               mem_wr    <= 4'b0000;
               rsp_valid <= 1'b0;
               rsp_fault <= 1'b0;
               req_ready <= 1'b1;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_data_port.sv
// Directed self-checking bench for lsu_data_port with behavioural byte-laned memories
// at read latencies 1 and 3.
module tb_lsu_data_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reqValid1, reqValid3, reqWe, reqUnsigned, rspReady;
   logic [1:0]  reqSize;
   logic [31:0] reqAddr, reqWdata;

   logic        reqReady1, rspValid1, rspFault1;
   logic [31:0] rspRdata1, memRaddr1, memWaddr1, memWdata1, memRdata1;
   logic [3:0]  memWr1;
   logic        reqReady3, rspValid3, rspFault3;
   logic [31:0] rspRdata3, memRaddr3, memWaddr3, memWdata3, memRdata3;
   logic [3:0]  memWr3;

   logic [31:0] mem1 [256];
   logic [31:0] mem3 [256];
   logic [31:0] pipe3a, pipe3b;

   int nCmp = 0;
   int nErr = 0;

   always #5 clk = ~clk;

   lsu_data_port #(.MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(reqValid1), .req_ready(reqReady1), .req_we(reqWe),
      .req_size(reqSize), .req_unsigned(reqUnsigned), .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid1), .rsp_ready(rspReady), .rsp_rdata(rspRdata1), .rsp_fault(rspFault1),
      .mem_raddr(memRaddr1), .mem_waddr(memWaddr1), .mem_wdata(memWdata1), .mem_wr(memWr1),
      .mem_rdata(memRdata1));

   lsu_data_port #(.MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(reqValid3), .req_ready(reqReady3), .req_we(reqWe),
      .req_size(reqSize), .req_unsigned(reqUnsigned), .req_addr(reqAddr), .req_wdata(reqWdata),
      .rsp_valid(rspValid3), .rsp_ready(rspReady), .rsp_rdata(rspRdata3), .rsp_fault(rspFault3),
      .mem_raddr(memRaddr3), .mem_waddr(memWaddr3), .mem_wdata(memWdata3), .mem_wr(memWr3),
      .mem_rdata(memRdata3));

   // Latency-1 synchronous memory with per-lane writes
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (memWr1[i]) mem1[memWaddr1[9:2]][8*i +: 8] <= memWdata1[8*i +: 8];
      memRdata1 <= mem1[memRaddr1[9:2]];
   end

   // Latency-3 synchronous memory
   always @(posedge clk) begin
      for (int j = 0; j < 4; j++)
         if (memWr3[j]) mem3[memWaddr3[9:2]][8*j +: 8] <= memWdata3[8*j +: 8];
      pipe3a    <= mem3[memRaddr3[9:2]];
      pipe3b    <= pipe3a;
      memRdata3 <= pipe3b;
   end

   task automatic issue(input logic sel3, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      reqWe = we; reqSize = size; reqUnsigned = uns; reqAddr = addr; reqWdata = wdata;
      if (sel3) reqValid3 = 1'b1;
      else      reqValid1 = 1'b1;
      @(negedge clk);
      reqValid1 = 1'b0;
      reqValid3 = 1'b0;
   endtask

   task automatic waitResp1(output int lat);
      lat = 0;
      while (!rspValid1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic waitResp3(output int lat);
      lat = 0;
      while (!rspValid3 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic ack();
      rspReady = 1'b1;
      @(negedge clk);
      rspReady = 1'b0;
   endtask

   task automatic doLoad(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         output logic [31:0] data, output logic fault, output int lat);
      issue(1'b0, 1'b0, size, uns, addr, 32'h0);
      waitResp1(lat);
      data  = rspRdata1;
      fault = rspFault1;
      ack();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      nCmp++; if (reqReady1 !== 1'b1) begin nErr++; $display("FAIL rst_req_ready: got %b required 1", reqReady1); end
      nCmp++; if (rspValid1 !== 1'b0) begin nErr++; $display("FAIL rst_rsp_valid: got %b required 0", rspValid1); end
      nCmp++; if (rspFault1 !== 1'b0) begin nErr++; $display("FAIL rst_rsp_fault: got %b required 0", rspFault1); end
      nCmp++; if (rspRdata1 !== 32'h0) begin nErr++; $display("FAIL rst_rsp_rdata: got %h required 0", rspRdata1); end
      nCmp++; if (memWr1 !== 4'b0000) begin nErr++; $display("FAIL rst_mem_wr: got %b required 0000", memWr1); end
      nCmp++; if ({memRaddr1, memWaddr1, memWdata1} !== 96'h0) begin
         nErr++; $display("FAIL rst_mem_bus: got %h %h %h required 0", memRaddr1, memWaddr1, memWdata1);
      end
      nCmp++; if (reqReady3 !== 1'b1) begin nErr++; $display("FAIL rst_req_ready3: got %b required 1", reqReady3); end
      rst_n = 1'b1;
      @(negedge clk);
      nCmp++; if (reqReady1 !== 1'b1) begin nErr++; $display("FAIL rel_req_ready: got %b required 1", reqReady1); end
   endtask

   task automatic test_word_store_load();
      int lat; logic [31:0] d; logic f;
      issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
      nCmp++; if (memWaddr1 !== 32'h100) begin nErr++; $display("FAIL sw_waddr: got %h required 00000100", memWaddr1); end
      nCmp++; if (memWr1 !== 4'b1111) begin nErr++; $display("FAIL sw_wr: got %b required 1111", memWr1); end
      nCmp++; if (memWdata1 !== 32'hDEADBEEF) begin nErr++; $display("FAIL sw_wdata: got %h required deadbeef", memWdata1); end
      nCmp++; if (reqReady1 !== 1'b0) begin nErr++; $display("FAIL sw_busy: got %b required 0", reqReady1); end
      waitResp1(lat);
      nCmp++; if (lat !== 1) begin nErr++; $display("FAIL sw_latency: got %0d required 1", lat); end
      nCmp++; if (memWr1 !== 4'b0000) begin nErr++; $display("FAIL sw_wr_drop: got %b required 0000", memWr1); end
      nCmp++; if ({rspFault1, rspRdata1} !== 33'h0) begin nErr++; $display("FAIL sw_rsp: got %b %h required 0 0", rspFault1, rspRdata1); end
      ack();
      issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      nCmp++; if (memRaddr1 !== 32'h100) begin nErr++; $display("FAIL lw_raddr: got %h required 00000100", memRaddr1); end
      waitResp1(lat);
      nCmp++; if (lat !== 2) begin nErr++; $display("FAIL lw_latency: got %0d required 2", lat); end
      nCmp++; if (rspRdata1 !== 32'hDEADBEEF) begin nErr++; $display("FAIL lw_data: got %h required deadbeef", rspRdata1); end
      ack();
      nCmp++; if (reqReady1 !== 1'b1) begin nErr++; $display("FAIL lw_ready_after: got %b required 1", reqReady1); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] bData [4] = '{32'h11, 32'h22, 32'h33, 32'h84};
      logic [31:0] expWd [4] = '{32'h0000_0011, 32'h0000_2200, 32'h0033_0000, 32'h8400_0000};
      logic [3:0]  expWr [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      int lat; logic [31:0] d; logic f;
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h200 + 32'(i), bData[i]);
         nCmp++; if (memWaddr1 !== 32'h200) begin nErr++; $display("FAIL sb_waddr[%0d]: got %h required 00000200", i, memWaddr1); end
         nCmp++; if (memWr1 !== expWr[i]) begin nErr++; $display("FAIL sb_wr[%0d]: got %b required %b", i, memWr1, expWr[i]); end
         nCmp++; if (memWdata1 !== expWd[i]) begin nErr++; $display("FAIL sb_wdata[%0d]: got %h required %h", i, memWdata1, expWd[i]); end
         waitResp1(lat);
         ack();
      end
      doLoad(2'b10, 1'b0, 32'h200, d, f, lat);
      nCmp++; if (d !== 32'h84332211) begin nErr++; $display("FAIL lb_word: got %h required 84332211", d); end
      doLoad(2'b00, 1'b0, 32'h203, d, f, lat);
      nCmp++; if (d !== 32'hFFFFFF84) begin nErr++; $display("FAIL lb_signed: got %h required ffffff84", d); end
      doLoad(2'b00, 1'b1, 32'h203, d, f, lat);
      nCmp++; if (d !== 32'h00000084) begin nErr++; $display("FAIL lb_unsigned: got %h required 00000084", d); end
      doLoad(2'b00, 1'b0, 32'h201, d, f, lat);
      nCmp++; if (d !== 32'h00000022) begin nErr++; $display("FAIL lb_signed_pos: got %h required 00000022", d); end
   endtask

   task automatic test_half();
      int lat; logic [31:0] d; logic f;
      issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h302, 32'h8001);
      nCmp++; if (memWaddr1 !== 32'h300) begin nErr++; $display("FAIL sh_waddr: got %h required 00000300", memWaddr1); end
      nCmp++; if (memWr1 !== 4'b1100) begin nErr++; $display("FAIL sh_wr: got %b required 1100", memWr1); end
      nCmp++; if (memWdata1 !== 32'h80010000) begin nErr++; $display("FAIL sh_wdata: got %h required 80010000", memWdata1); end
      waitResp1(lat);
      ack();
      doLoad(2'b01, 1'b0, 32'h302, d, f, lat);
      nCmp++; if (d !== 32'hFFFF8001) begin nErr++; $display("FAIL lh_signed: got %h required ffff8001", d); end
      doLoad(2'b01, 1'b1, 32'h302, d, f, lat);
      nCmp++; if (d !== 32'h00008001) begin nErr++; $display("FAIL lh_unsigned: got %h required 00008001", d); end
      doLoad(2'b10, 1'b0, 32'h300, d, f, lat);
      nCmp++; if (d !== 32'h80010000) begin nErr++; $display("FAIL lh_word: got %h required 80010000", d); end
   endtask

   task automatic test_faults();
      logic        fWe   [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  fSize [3] = '{2'b01, 2'b10, 2'b11};
      logic [31:0] fAddr [3] = '{32'h101, 32'h102, 32'h100};
      int lat; logic sawWr; logic [31:0] d; logic f;
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, fWe[i], fSize[i], 1'b0, fAddr[i], 32'h5555_5555);
         sawWr = (memWr1 != 4'b0000);
         lat = 0;
         while (!rspValid1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (memWr1 != 4'b0000) sawWr = 1'b1;
         end
         nCmp++; if (lat !== 0) begin nErr++; $display("FAIL flt_latency[%0d]: got %0d required 0", i, lat); end
         nCmp++; if (rspFault1 !== 1'b1) begin nErr++; $display("FAIL flt_fault[%0d]: got %b required 1", i, rspFault1); end
         nCmp++; if (rspRdata1 !== 32'h0) begin nErr++; $display("FAIL flt_rdata[%0d]: got %h required 0", i, rspRdata1); end
         nCmp++; if (sawWr !== 1'b0) begin nErr++; $display("FAIL flt_no_write[%0d]: got %b required 0", i, sawWr); end
         ack();
         nCmp++; if ({rspValid1, rspFault1} !== 2'b00) begin nErr++; $display("FAIL flt_clear[%0d]: got %b required 00", i, {rspValid1, rspFault1}); end
      end
      doLoad(2'b10, 1'b0, 32'h100, d, f, lat);
      nCmp++; if ({f, d} !== {1'b0, 32'hDEADBEEF}) begin nErr++; $display("FAIL flt_mem_intact: got %b %h required 0 deadbeef", f, d); end
   endtask

   task automatic test_backpressure();
      int lat; logic [31:0] d; logic f;
      issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
      waitResp1(lat);
      nCmp++; if (lat !== 2) begin nErr++; $display("FAIL bp_latency: got %0d required 2", lat); end
      for (int k = 0; k < 5; k++) begin
         nCmp++; if ({rspValid1, reqReady1, memWr1} !== 6'b100000) begin
            nErr++; $display("FAIL bp_hold[%0d]: got valid=%b ready=%b wr=%b required 1 0 0000", k, rspValid1, reqReady1, memWr1);
         end
         nCmp++; if (rspRdata1 !== 32'h84332211) begin nErr++; $display("FAIL bp_data[%0d]: got %h required 84332211", k, rspRdata1); end
         if (k == 1) begin
            reqWe = 1'b1; reqSize = 2'b10; reqAddr = 32'h200; reqWdata = 32'h0; reqValid1 = 1'b1;
         end else begin
            reqValid1 = 1'b0;
         end
         @(negedge clk);
      end
      ack();
      nCmp++; if ({rspValid1, reqReady1} !== 2'b01) begin nErr++; $display("FAIL bp_release: got %b required 01", {rspValid1, reqReady1}); end
      doLoad(2'b10, 1'b0, 32'h200, d, f, lat);
      nCmp++; if (d !== 32'h84332211) begin nErr++; $display("FAIL bp_ignored_req: got %h required 84332211", d); end
   endtask

   task automatic test_async_reset();
      int lat; logic [31:0] d; logic f; logic sawValid;
      issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h3F0, 32'h12345678);
      nCmp++; if (memWr1 !== 4'b1111) begin nErr++; $display("FAIL ar_store_wr: got %b required 1111", memWr1); end
      #2 rst_n = 1'b0;
      #1;
      nCmp++; if ({memWr1, rspValid1, reqReady1} !== 6'b000001) begin
         nErr++; $display("FAIL ar_store_abort: got wr=%b valid=%b ready=%b required 0000 0 1", memWr1, rspValid1, reqReady1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      nCmp++; if ({reqReady1, rspValid1} !== 2'b10) begin nErr++; $display("FAIL ar_store_idle: got %b required 10", {reqReady1, rspValid1}); end
      doLoad(2'b10, 1'b0, 32'h3F0, d, f, lat);
      nCmp++; if (d !== 32'h0) begin nErr++; $display("FAIL ar_no_write: got %h required 00000000", d); end

      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      nCmp++; if (reqReady3 !== 1'b0) begin nErr++; $display("FAIL ar_load_busy: got %b required 0", reqReady3); end
      #2 rst_n = 1'b0;
      #1;
      nCmp++; if ({memWr3, rspValid3, reqReady3} !== 6'b000001) begin
         nErr++; $display("FAIL ar_load_abort: got wr=%b valid=%b ready=%b required 0000 0 1", memWr3, rspValid3, reqReady3);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sawValid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rspValid3) sawValid = 1'b1;
      end
      nCmp++; if ({sawValid, reqReady3} !== 2'b01) begin nErr++; $display("FAIL ar_load_quiet: got %b required 01", {sawValid, reqReady3}); end

      issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D);
      nCmp++; if (memWr3 !== 4'b1111) begin nErr++; $display("FAIL l3_store_wr: got %b required 1111", memWr3); end
      waitResp3(lat);
      ack();
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      waitResp3(lat);
      nCmp++; if (lat !== 4) begin nErr++; $display("FAIL l3_latency: got %0d required 4", lat); end
      nCmp++; if ({rspFault3, rspRdata3} !== {1'b0, 32'hCAFEF00D}) begin
         nErr++; $display("FAIL l3_data: got %b %h required 0 cafef00d", rspFault3, rspRdata3);
      end
      ack();
   endtask

   initial begin
      rst_n = 1'b0;
      reqValid1 = 1'b0; reqValid3 = 1'b0; reqWe = 1'b0; reqUnsigned = 1'b0; rspReady = 1'b0;
      reqSize = 2'b00; reqAddr = 32'h0; reqWdata = 32'h0;
      for (int m = 0; m < 256; m++) begin
         mem1[m] = 32'h0;
         mem3[m] = 32'h0;
      end
      test_reset();
      test_word_store_load();
      test_byte_lanes();
      test_half();
      test_faults();
      test_backpressure();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

endmodule
